// File: rtl/spiker_stream_adapter.sv
// Streams a snapshotted spike frame to a spiking core in CHUNK-bit beats, collects result frames
// over a programmable number of timesteps and OR-accumulates them into a CSR-visible result.
module spiker_stream_adapter #(
    parameter  int WIDTH      = 32,
    parameter  int N_SPIKES   = 784,
    parameter  int CHUNK      = 16,
    parameter  int STEP_W     = 8,
    localparam int N_REG      = (N_SPIKES + WIDTH - 1) / WIDTH,
    localparam int DATA_WIDTH = N_REG * WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic [DATA_WIDTH-1:0] spikes_i,
    input  logic [STEP_W-1:0]     n_steps_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    output logic                  in_valid_o,
    input  logic                  in_ready_i,
    output logic [CHUNK-1:0]      in_data_o,
    output logic                  in_last_o,
    input  logic                  out_valid_i,
    output logic                  out_ready_o,
    input  logic [CHUNK-1:0]      out_data_i,
    input  logic                  out_last_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int N_BEATS = (N_SPIKES + CHUNK - 1) / CHUNK;
    localparam int FRAME_W = N_BEATS * CHUNK;
    localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_RECV,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [FRAME_W-1:0]   result_q, result_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [STEP_W-1:0]    nsteps_q, nsteps_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [STEP_W-1:0]    step_inc;
    logic                 last_beat;
    logic                 unused_inputs;

    assign step_inc  = step_q + 1'b1;
    assign last_beat = (beat_q == LAST_BEAT);

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        result_d = result_q;
        beat_d   = beat_q;
        step_d   = step_q;
        nsteps_d = nsteps_q;
        done_d   = done_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    frame_d  = FRAME_W'(spikes_i[N_SPIKES-1:0]);
                    nsteps_d = (n_steps_i == '0) ? STEP_W'(1) : n_steps_i;
                    result_d = '0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    beat_d   = '0;
                    step_d   = '0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                if (in_ready_i) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = S_RECV;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (out_valid_i) begin
                    result_d = result_q | (FRAME_W'(out_data_i) << (beat_q * CHUNK));
                    // Framing errors are flagged but the beat still counts, so the run stays aligned.
                    if (out_last_i != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        beat_d = '0;
                        step_d = step_inc;
                        if (step_inc == nsteps_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_SEND;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_i) begin
            state_d  = S_IDLE;
            result_d = '0;
            beat_d   = '0;
            step_d   = '0;
            done_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            beat_q   <= '0;
            step_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            beat_q   <= beat_d;
            step_q   <= step_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Snapshot and step limit are only read while busy, so they need no reset.
    always_ff @(posedge clk_i) begin
        frame_q  <= frame_d;
        nsteps_q <= nsteps_d;
    end

    assign in_valid_o  = (state_q == S_SEND);
    assign out_ready_o = (state_q == S_RECV);
    assign in_data_o   = in_valid_o ? frame_q[beat_q * CHUNK +: CHUNK] : '0;
    assign in_last_o   = in_valid_o && last_beat;
    assign busy_o      = in_valid_o || out_ready_o;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign result_o    = DATA_WIDTH'(result_q[N_SPIKES-1:0]);

    assign unused_inputs = ^{test_mode_i, spikes_i};

endmodule

// File: tb/tb_spiker_stream_adapter.sv
// Directed-sequence bench for spiker_stream_adapter with a randomized core model and an
// OR-accumulation reference computed from frame-level arithmetic.
module tb_spiker_stream_adapter;

    localparam int WIDTH    = 32;
    localparam int N_SPIKES = 784;
    localparam int CHUNK    = 16;
    localparam int STEP_W   = 8;
    localparam int DW       = ((N_SPIKES + WIDTH - 1) / WIDTH) * WIDTH;
    localparam int NB       = (N_SPIKES + CHUNK - 1) / CHUNK;

    logic              clk;
    logic              rst_ni;
    logic              test_mode_i;
    logic [DW-1:0]     spikes_i;
    logic [STEP_W-1:0] n_steps_i;
    logic              start_i;
    logic              clear_i;
    logic              in_valid_o;
    logic              in_ready_i;
    logic [CHUNK-1:0]  in_data_o;
    logic              in_last_o;
    logic              out_valid_i;
    logic              out_ready_o;
    logic [CHUNK-1:0]  out_data_i;
    logic              out_last_i;
    logic [DW-1:0]     result_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    int vectors     = 0;
    int miscompares = 0;

    spiker_stream_adapter #(
        .WIDTH    (WIDTH),
        .N_SPIKES (N_SPIKES),
        .CHUNK    (CHUNK),
        .STEP_W   (STEP_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .test_mode_i (test_mode_i),
        .spikes_i    (spikes_i),
        .n_steps_i   (n_steps_i),
        .start_i     (start_i),
        .clear_i     (clear_i),
        .in_valid_o  (in_valid_o),
        .in_ready_i  (in_ready_i),
        .in_data_o   (in_data_o),
        .in_last_o   (in_last_o),
        .out_valid_i (out_valid_i),
        .out_ready_o (out_ready_o),
        .out_data_i  (out_data_i),
        .out_last_i  (out_last_i),
        .result_o    (result_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_frame();
        logic [DW-1:0] f;
        for (int i = 0; i < DW / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays the core: consumes input beats, returns result beats, and keeps the expected result.
    // mode 0: echo the frame, 1: step k returns bit k in beat 0, 2: random data.
    task automatic run(input logic [DW-1:0] spk, input int nreq, input int mode, input int stall,
                       input int err_beat, input bit glitch,
                       output int cycles, output logic [DW-1:0] exp_res);
        logic [N_SPIKES-1:0] frame;
        logic [CHUNK-1:0]    ret;
        int                  eff;
        int                  idx;
        bit                  acc;
        frame     = spk[N_SPIKES-1:0];
        eff       = (nreq == 0) ? 1 : nreq;
        exp_res   = '0;
        spikes_i  = spk;
        n_steps_i = STEP_W'(nreq);
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        cycles  = 1;
        chk("busy_after_start", DW'(busy_o), DW'(1));
        for (int s = 0; s < eff; s++) begin
            idx = 0;
            while (idx < NB) begin
                chk("in_valid", DW'(in_valid_o), DW'(1));
                chk("out_ready_in_send", DW'(out_ready_o), DW'(0));
                chk("in_data", DW'(in_data_o), DW'(frame[idx*CHUNK +: CHUNK]));
                chk("in_last", DW'(in_last_o), DW'(idx == NB - 1));
                acc        = ($urandom_range(99) >= stall);
                in_ready_i = acc;
                start_i    = glitch && (s == 0) && (idx == 5);
                if (start_i) begin
                    spikes_i  = rand_frame();
                    n_steps_i = 8'd7;
                end
                tick();
                cycles++;
                start_i = 1'b0;
                if (acc) idx++;
            end
            in_ready_i = 1'b0;
            idx = 0;
            while (idx < NB) begin
                chk("out_ready", DW'(out_ready_o), DW'(1));
                chk("in_valid_in_recv", DW'(in_valid_o), DW'(0));
                acc = ($urandom_range(99) >= stall);
                case (mode)
                    0:       ret = frame[idx*CHUNK +: CHUNK];
                    1:       ret = (idx == 0) ? (CHUNK'(1) << s) : '0;
                    default: ret = CHUNK'($urandom);
                endcase
                out_valid_i = acc;
                out_data_i  = acc ? ret : CHUNK'($urandom);
                out_last_i  = (idx == NB - 1) ^ (idx == err_beat);
                if (acc) exp_res = exp_res | (DW'(ret) << (idx * CHUNK));
                tick();
                cycles++;
                if (acc) idx++;
            end
            out_valid_i = 1'b0;
            out_last_i  = 1'b0;
        end
        exp_res = exp_res & {{(DW - N_SPIKES){1'b0}}, {N_SPIKES{1'b1}}};
        chk("done", DW'(done_o), DW'(1));
        chk("busy_at_done", DW'(busy_o), DW'(0));
        chk("result", result_o, exp_res);
        chk("err", DW'(err_o), DW'(err_beat >= 0 && err_beat < NB));
        chk("no_extra_frame", DW'(in_valid_o), DW'(0));
    endtask

    initial begin
        logic [DW-1:0] spk;
        logic [DW-1:0] exp_res;
        logic [DW-1:0] held;
        int            cycles;

        rst_ni      = 1'b0;
        test_mode_i = 1'b0;
        spikes_i    = '0;
        n_steps_i   = '0;
        start_i     = 1'b0;
        clear_i     = 1'b0;
        in_ready_i  = 1'b0;
        out_valid_i = 1'b0;
        out_data_i  = '0;
        out_last_i  = 1'b0;
        tick();
        tick();
        chk("rst_in_valid", DW'(in_valid_o), DW'(0));
        chk("rst_out_ready", DW'(out_ready_o), DW'(0));
        chk("rst_in_data", DW'(in_data_o), DW'(0));
        chk("rst_in_last", DW'(in_last_o), DW'(0));
        chk("rst_result", result_o, '0);
        chk("rst_busy", DW'(busy_o), DW'(0));
        chk("rst_done", DW'(done_o), DW'(0));
        chk("rst_err", DW'(err_o), DW'(0));
        rst_ni = 1'b1;
        tick();

        // Echo, single step, no stalls.
        spk = rand_frame();
        run(spk, 1, 0, 0, -1, 1'b0, cycles, exp_res);
        chk("echo_latency", DW'(cycles), DW'(99));
        chk("echo_result", result_o, DW'(spk[N_SPIKES-1:0]));
        held = result_o;
        out_valid_i = 1'b1;
        out_data_i  = 16'hFFFF;
        repeat (3) tick();
        out_valid_i = 1'b0;
        chk("result_stable_done", result_o, held);

        // Three steps, step k sets bit k; a start pulse mid-run must be ignored.
        spk = rand_frame();
        run(spk, 3, 1, 0, -1, 1'b1, cycles, exp_res);
        chk("steps3_word0", DW'(result_o[31:0]), DW'(32'h7));
        chk("steps3_latency", DW'(cycles), DW'(1 + 2 * NB * 3));

        // n_steps = 0 behaves as one step.
        spk = rand_frame();
        run(spk, 0, 0, 0, -1, 1'b0, cycles, exp_res);
        chk("nsteps0_latency", DW'(cycles), DW'(99));

        // Random stalls on both streams, random result data.
        spk = rand_frame();
        run(spk, 2, 2, 40, -1, 1'b0, cycles, exp_res);

        // Early last marker on beat 10, then clear.
        spk = rand_frame();
        run(spk, 1, 0, 20, 10, 1'b0, cycles, exp_res);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_done", DW'(done_o), DW'(0));
        chk("clr_err", DW'(err_o), DW'(0));
        chk("clr_result", result_o, '0);
        chk("clr_busy", DW'(busy_o), DW'(0));

        // Clear while beat 20 is being offered and accepted.
        spk       = rand_frame();
        spikes_i  = spk;
        n_steps_i = 8'd1;
        start_i   = 1'b1;
        tick();
        start_i    = 1'b0;
        in_ready_i = 1'b1;
        repeat (20) tick();
        chk("beat20_data", DW'(in_data_o), DW'(spk[20*CHUNK +: CHUNK]));
        clear_i = 1'b1;
        tick();
        clear_i    = 1'b0;
        in_ready_i = 1'b0;
        chk("midclr_in_valid", DW'(in_valid_o), DW'(0));
        chk("midclr_in_data", DW'(in_data_o), DW'(0));
        chk("midclr_result", result_o, '0);
        chk("midclr_busy", DW'(busy_o), DW'(0));

        // Asynchronous reset mid-run, then a normal run.
        spikes_i  = rand_frame();
        n_steps_i = 8'd2;
        start_i   = 1'b1;
        tick();
        start_i    = 1'b0;
        in_ready_i = 1'b1;
        repeat (5) tick();
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_busy", DW'(busy_o), DW'(0));
        chk("arst_in_valid", DW'(in_valid_o), DW'(0));
        chk("arst_in_data", DW'(in_data_o), DW'(0));
        in_ready_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        spk = rand_frame();
        run(spk, 1, 0, 30, -1, 1'b0, cycles, exp_res);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
